// File: rtl/tip_arty_reset_seq.sv
// Reset sequencer: turns an asynchronous board reset and the PLL lock into two
// ordered, synchronously released resets (peripherals first, then the core).
module tip_arty_reset_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int CORE_DELAY     = 8
) (
  input  logic       clk_system,
  input  logic       external_rstnn,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  output logic       rstnn_periph,
  output logic       rstnn_core,
  output logic       reset_done,
  output logic [1:0] reset_cause
);

  localparam int MAX_COUNT = (STRETCH_CYCLES > CORE_DELAY) ? STRETCH_CYCLES : CORE_DELAY;
  localparam int CW        = $clog2(MAX_COUNT + 1);

  localparam logic [1:0] CAUSE_EXT  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STRETCH,
    ST_PERIPH_ON,
    ST_RUN
  } state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          count, count_next;
  logic [SYNC_STAGES-1:0] rst_chain, lock_chain;
  logic                   rst_sync, lock_sync;
  logic                   periph_next, core_next;
  logic [1:0]             cause_next;

  // NOTE: every flop here is cleared asynchronously by the board reset, so the
  // outputs drop with zero latency even when clk_system is not running.
  always_ff @(posedge clk_system or negedge external_rstnn) begin
    if (!external_rstnn) begin
      rst_chain  <= '0;
      lock_chain <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour, giving a true shift chain.
      rst_chain  <= {rst_chain[SYNC_STAGES-2:0], 1'b1};
      lock_chain <= {lock_chain[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign rst_sync  = rst_chain[SYNC_STAGES-1];
  assign lock_sync = lock_chain[SYNC_STAGES-1];

  always_comb begin
    // NOTE: defaults first, so no path through this block can infer a latch.
    state_next  = state;
    periph_next = rstnn_periph;
    core_next   = rstnn_core;
    cause_next  = reset_cause;
    unique case (state)
      ST_RESET:     if (rst_sync) state_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (lock_sync) state_next = ST_STRETCH;
      ST_STRETCH, ST_PERIPH_ON, ST_RUN: begin
        // Lock loss outranks a software request arriving in the same cycle.
        if (!lock_sync) begin
          state_next  = ST_WAIT_LOCK;
          periph_next = 1'b0;
          core_next   = 1'b0;
          cause_next  = CAUSE_LOCK;
        end else if (state == ST_RUN && sw_rst_req) begin
          state_next  = ST_WAIT_LOCK;
          periph_next = 1'b0;
          core_next   = 1'b0;
          cause_next  = CAUSE_SW;
        end else if (state == ST_STRETCH && count == CW'(STRETCH_CYCLES - 1)) begin
          state_next  = ST_PERIPH_ON;
          periph_next = 1'b1;
        end else if (state == ST_PERIPH_ON && count == CW'(CORE_DELAY - 1)) begin
          state_next = ST_RUN;
          core_next  = 1'b1;
        end
      end
      default: state_next = ST_RESET;
    endcase

    count_next = '0;
    if (state_next == state && (state == ST_STRETCH || state == ST_PERIPH_ON))
      count_next = count + CW'(1);
  end

  always_ff @(posedge clk_system or negedge external_rstnn) begin
    if (!external_rstnn) begin
      state        <= ST_RESET;
      count        <= '0;
      rstnn_periph <= 1'b0;
      rstnn_core   <= 1'b0;
      reset_done   <= 1'b0;
      reset_cause  <= CAUSE_EXT;
    end else begin
      state        <= state_next;
      count        <= count_next;
      rstnn_periph <= periph_next;
      rstnn_core   <= core_next;
      reset_done   <= core_next;
      reset_cause  <= cause_next;
    end
  end

endmodule

// File: doc/tip_arty_reset_seq.md
# tip_arty_reset_seq

Reset sequencer for the Arty platform. It sits directly downstream of the platform clock/PLL stage and consumes `clk_system` and the PLL lock indication. From an external asynchronous board reset it produces two ordered reset domains: peripherals are released first and the core later. Each reset asserts asynchronously and deasserts synchronously to `clk_system`. It also reports reset completion and the cause of the last reset.

## Interface
Parameters:
- `SYNC_STAGES`, 2: depth of each synchronizer chain; must be ≥2.
- `STRETCH_CYCLES`, 16: `clk_system` cycles held in STRETCH before peripherals are released; must be ≥1.
- `CORE_DELAY`, 8: cycles between peripheral release and core release; must be ≥1.

Ports:
- `clk_system` in 1: the single clock, from the PLL stage.
- `external_rstnn` in 1: reset, asynchronous, active-low. It clears every flop in the block.
- `pll_locked` in 1: PLL lock, asynchronous to `clk_system`; synchronized internally.
- `sw_rst_req` in 1: synchronous software reset request, sampled on `clk_system`.
- `rstnn_periph` out 1: active-low peripheral reset.
- `rstnn_core` out 1: active-low core reset.
- `reset_done` out 1: high only in state RUN.
- `reset_cause` out 2: cause of the last reset. 0 = external, 1 = lock loss, 2 = software, 3 = unused.

## Operation
- Synchronizers:
  - The external reset is passed through a `SYNC_STAGES` chain that is async-cleared and shifts in 1; its output is `rst_sync`.
  - `pll_locked` is passed through a separate `SYNC_STAGES` chain that is async-cleared; its output is `lock_sync`.
- Counter:
  - One shared counter, width `$clog2(max(STRETCH_CYCLES, CORE_DELAY)+1)`.
  - It is cleared on every state entry and increments once per cycle in STRETCH and PERIPH_ON.
- State machine and transitions:
  - RESET → WAIT_LOCK when `rst_sync` = 1.
  - WAIT_LOCK → STRETCH when `lock_sync` = 1.
  - STRETCH → PERIPH_ON when count = `STRETCH_CYCLES`-1. On this edge `rstnn_periph` is registered to 1.
  - PERIPH_ON → RUN when count = `CORE_DELAY`-1. On this edge `rstnn_core` and `reset_done` are registered to 1.
  - From STRETCH, PERIPH_ON or RUN: if `lock_sync` = 0 → WAIT_LOCK. On that edge both resets are registered to 0, `reset_done` to 0, `reset_cause` to 1.
  - RUN with `sw_rst_req` = 1 → WAIT_LOCK. On that edge both resets and `reset_done` are registered to 0, `reset_cause` to 2.
- Priorities and ignored events:
  - Lock loss has priority over `sw_rst_req`; if both occur, the cause is 1.
  - `sw_rst_req` outside RUN is ignored.
  - Lock loss in WAIT_LOCK keeps the state and has no other effect.
- External reset:
  - `external_rstnn` = 0 in any state immediately clears all state, the synchronizers and the outputs.
  - `reset_cause` is set to 0.
- Output flops:
  - All outputs come from flops, with no combinational paths to outputs.
  - The output flops are async-cleared by `external_rstnn` only.
  - Software and lock-loss resets reach the outputs only through these flops.

## Timing
- Reset value of every output: `rstnn_periph` = 0, `rstnn_core` = 0, `reset_done` = 0, `reset_cause` = 0.
- Assertion:
  - External reset: asynchronous, with zero-cycle latency.
  - Lock loss and software reset: synchronous.
- Edge numbering convention: "edge n" means the n-th rising edge of `clk_system` at which an input is sampled at its new value (edge 1 = the first such edge).
- External release with `pll_locked` already high:
  - `rst_sync` and `lock_sync` go high after edge `SYNC_STAGES`.
  - WAIT_LOCK is entered at edge `SYNC_STAGES`+1 and STRETCH at edge `SYNC_STAGES`+2.
  - `rstnn_periph` rises at edge `SYNC_STAGES`+2+`STRETCH_CYCLES`.
  - `rstnn_core` and `reset_done` rise `CORE_DELAY` edges later.
  - With defaults: 20 and 28.
- Lock first sampled high at edge L while in WAIT_LOCK: STRETCH is entered at edge L+`SYNC_STAGES`; `rstnn_periph` rises at L+`SYNC_STAGES`+`STRETCH_CYCLES`.
- Lock first sampled low at edge L: outputs go low at edge L+`SYNC_STAGES`.
- `sw_rst_req` sampled at edge E in RUN:
  - Outputs go low at edge E; STRETCH is entered at edge E+1.
  - `rstnn_periph` rises at E+1+`STRETCH_CYCLES` and `rstnn_core` at E+1+`STRETCH_CYCLES`+`CORE_DELAY`.
- Ordering guarantees:
  - `rstnn_core` is never 1 while `rstnn_periph` is 0.
  - `reset_done` equals `rstnn_core`.

## Test plan
- Power-on, defaults: hold `pll_locked` = 1 and release `external_rstnn` before edge 1. Required: `rstnn_periph` rises at edge 20; `rstnn_core` and `reset_done` rise at edge 28; `reset_cause` = 0.
- Late lock: `pll_locked` is first sampled high at edge 40. Required: STRETCH at 42, `rstnn_periph` at 58, `rstnn_core` at 66; both stay 0 before that.
- Lock loss in RUN: `pll_locked` is first sampled low at edge 100. Required: both resets 0 and `reset_cause` = 1 at edge 102. Lock is restored first-sampled at edge 110 → `rstnn_periph` at 128, `rstnn_core` at 136.
- Software reset: one-cycle `sw_rst_req` at edge 200 in RUN. Required: outputs 0 at edge 200, `reset_cause` = 2, `rstnn_periph` at 217, `rstnn_core` at 225. A second pulse during STRETCH is ignored and the timing is unchanged.
- Mid-sequence external reset: drive `external_rstnn` low at edge 10 (during STRETCH), between clock edges. Required: outputs 0 immediately with no clock, `reset_cause` = 0; after release the full 20/28 sequence replays.
- Simultaneous events: `sw_rst_req` high in the same cycle that `lock_sync` falls in RUN. Required: `reset_cause` = 1, state WAIT_LOCK, and no release until lock returns.
